// File: rtl/puf_response_collector_if.sv
// Handshake/bus bundle for puf_response_collector: start/seed request, PUF challenge/response,
// and the key word hand-off to the consumer.
interface puf_response_collector_if #(
  parameter int N     = 4,
  parameter int KEY_W = 16
);
  localparam int CNT_W = $clog2(KEY_W + 1);

  logic             start;
  logic [N-1:0]     seed;
  logic [N-1:0]     challenge;
  logic             puf_resp;
  logic             busy;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_ready;
  logic [CNT_W-1:0] unstable_cnt;

  modport master (
    output start, seed, puf_resp, key_ready,
    input  challenge, busy, key, key_valid, unstable_cnt
  );

  modport slave (
    input  start, seed, puf_resp, key_ready,
    output challenge, busy, key, key_valid, unstable_cnt
  );
endinterface

// File: rtl/puf_response_collector.sv
// Collects KEY_W majority-voted PUF response bits into a key word over a start/valid-ready handshake.
// Optional macro PUF_STABILITY_EN builds the non-unanimous-bit counter on unstable_cnt.
module puf_response_collector #(
  parameter int N      = 4,
  parameter int KEY_W  = 16,
  parameter int SETTLE = 4,
  parameter int VOTES  = 3
) (
  input logic                    clk,
  input logic                    rst,
  puf_response_collector_if.slave bus
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [N-1:0]     challenge_q;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic [SW-1:0]    settle_cnt;
  logic [VW-1:0]    vote_cnt;
  logic [VW-1:0]    ones_cnt;
  logic [BW-1:0]    bit_cnt;

  logic             accept;
  logic             sample;
  logic             decide;
  logic             settle_done;
  logic [VW-1:0]    ones_total;
  logic             bit_val;

  assign settle_done = (settle_cnt == SW'(SETTLE - 1));
  assign ones_total  = ones_cnt + VW'(bus.puf_resp);
  assign bit_val     = (ones_total > VW'(VOTES / 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    decide     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (settle_done) state_next = SAMPLE;
      end
      SAMPLE: begin
        sample = 1'b1;
        if (vote_cnt == VW'(VOTES - 1)) begin
          decide     = 1'b1;
          state_next = (bit_cnt == BW'(KEY_W - 1)) ? DONE : APPLY;
        end else begin
          state_next = APPLY;
        end
      end
      DONE: begin
        if (key_valid_q && bus.key_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // key_valid is registered off the DONE state, so it lags DONE entry by one cycle
  // and DONE only exits once the consumer has actually seen it high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      challenge_q <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      settle_cnt  <= '0;
      vote_cnt    <= '0;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
    end else begin
      key_valid_q <= (state == DONE) && !(key_valid_q && bus.key_ready);
      if (accept) begin
        challenge_q <= bus.seed;
        key_q       <= '0;
        settle_cnt  <= '0;
        vote_cnt    <= '0;
        ones_cnt    <= '0;
        bit_cnt     <= '0;
      end
      if (state == APPLY) begin
        settle_cnt <= settle_done ? '0 : settle_cnt + SW'(1);
      end
      if (sample) begin
        if (decide) begin
          key_q       <= (key_q << 1) | KEY_W'(bit_val);
          challenge_q <= challenge_q + N'(1);
          vote_cnt    <= '0;
          ones_cnt    <= '0;
          bit_cnt     <= bit_cnt + BW'(1);
        end else begin
          vote_cnt <= vote_cnt + VW'(1);
          ones_cnt <= ones_total;
        end
      end
    end
  end

`ifdef PUF_STABILITY_EN
  logic [BW-1:0] unstable_q;
  logic          unanimous;

  assign unanimous = (ones_total == '0) || (ones_total == VW'(VOTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unstable_q <= '0;
    end else if (accept) begin
      unstable_q <= '0;
    end else if (decide && !unanimous) begin
      unstable_q <= unstable_q + BW'(1);
    end
  end

  assign bus.unstable_cnt = unstable_q;
`else
  assign bus.unstable_cnt = '0;
`endif

  assign bus.challenge = challenge_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 The block SHALL have the parameter N, default 4: challenge width in bits, matching the upstream PUF challenge input.
REQ-002 The block SHALL have the parameter KEY_W, default 16: number of response bits assembled into one key word.
REQ-003 The block SHALL have the parameter SETTLE, default 4: cycles a challenge is held before sampling; legal values are 1 or more.
REQ-004 The block SHALL have the parameter VOTES, default 3: evaluations per key bit; it SHALL be odd and 1 or more.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: request to collect one key word.
REQ-008 The block SHALL have port seed, input, N bits: first challenge, captured when start is accepted.
REQ-009 The block SHALL have port challenge, output, N bits: drives the PUF challenge input; registered.
REQ-010 The block SHALL have port puf_resp, input, 1 bit: single-bit PUF response.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port key, output, KEY_W bits: assembled key word; registered.
REQ-013 The block SHALL have port key_valid, output, 1 bit: key holds a complete word.
REQ-014 The block SHALL have port key_ready, input, 1 bit: consumer accepts the key.
REQ-015 The block SHALL have port unstable_cnt, output, $clog2(KEY_W+1) bits: count of non-unanimous bits (see Configuration).

Function
REQ-016 The state machine SHALL have the states IDLE, APPLY, SAMPLE and DONE.
REQ-017 IDLE with start=1 SHALL load challenge<=seed, clear key, the vote, bit and unstable counters, and go to APPLY.
REQ-018 In APPLY, challenge SHALL be held for exactly SETTLE cycles, then the block SHALL go to SAMPLE.
REQ-019 SAMPLE SHALL last 1 cycle: add puf_resp to the ones count and increment the vote count.
REQ-020 If votes taken < VOTES after SAMPLE, the block SHALL return to APPLY with the same challenge.
REQ-021 If votes taken = VOTES after SAMPLE, the bit SHALL be 1 when ones > VOTES/2 (integer), else 0.
REQ-022 The decided bit SHALL shift in at the LSB: key<={key[KEY_W-2:0],bit}, so the first bit ends at the MSB.
REQ-023 After each decided bit, challenge SHALL be incremented modulo 2^N (all-ones wraps to 0), and the vote and ones counts cleared.
REQ-024 After KEY_W bits, the block SHALL go to DONE; otherwise it SHALL go to APPLY.
REQ-025 key_valid SHALL be 1 only in DONE, and first rises KEY_W*VOTES*(SETTLE+1)+1 cycles after the start-accept edge (241 at defaults).
REQ-026 In DONE, key and key_valid SHALL stay stable until key_ready=1; on the key_valid&key_ready edge the block SHALL go to IDLE, and key keeps its value.
REQ-027 start SHALL be ignored outside IDLE, including in the DONE handshake cycle; key_ready SHALL be ignored outside DONE.
REQ-028 puf_resp SHALL be sampled only in SAMPLE; its value in other states SHALL have no effect.

Reset
REQ-029 rst=1 SHALL force state to IDLE immediately, regardless of clk, including mid-collection or mid-handshake.
REQ-030 During reset, challenge, key, key_valid, busy, unstable_cnt and all internal counters SHALL be 0.
REQ-031 After rst is released, the first start SHALL be honoured on the next clk edge.

Configuration
REQ-032 With PUF_STABILITY_EN defined, unstable_cnt SHALL increment on each decided bit whose ones count is neither 0 nor VOTES; it SHALL be cleared on start-accept and held through DONE and IDLE.
REQ-033 Without PUF_STABILITY_EN, unstable_cnt SHALL be constant 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-034 Defaults, seed=4'hE, puf_resp tied 1 -> key_valid at cycle 241, key=16'hFFFF, challenge sequence E,F,0,1,... (wrap checked).
REQ-035 puf_resp = challenge[0] -> key=16'h5555 for seed=0; challenge constant across every APPLY/SAMPLE span of a bit.
REQ-036 VOTES=3, responses 1,0,1 for bit 0 and 0,0,1 for bit 1, all others 0, PUF_STABILITY_EN defined -> key=16'h8000 (bit1=0), unstable_cnt=2; without the macro unstable_cnt=0.
REQ-037 key_ready held 0 for 10 cycles in DONE -> key and key_valid stable; start pulses during DONE and collection have no effect; key_ready=1 -> IDLE next cycle.
REQ-038 rst asserted between clk edges at cycle 100 -> all outputs 0 immediately; a new start after release gives a full 241-cycle collection.
